// File: rtl/fix_field_store.sv
// fix_field_store
//   Parses an ASCII FIX byte stream ("tag=value<SOH>...10=ccc<SOH>") into a
//   small field table. The table can then be searched by binary tag number.
//
//   Build option: FIX_CHECKSUM_CHECK_EN. When it is defined, msg_ok_o also
//   requires the computed checksum to match the decoded tag-10 value.
//
// Ports
//   clk, rst                  clock, synchronous active-low reset
//   data_i/_valid_i/_ready_o  byte stream input with valid/ready handshake
//   find_tag_i, lookup_req_i  lookup request (accepted in IDLE only)
//   lookup_done_o/_hit_o      lookup completion pulse and hit flag
//   value_o, value_len_o      matched value bytes (byte 0 in bits [7:0]) and length
//   msg_done_o, msg_ok_o      end/abort pulse and held message status
//   field_count_o             fields stored for the current/last message
//   checksum_o                computed checksum of the last completed message
//   overflow_o                sticky table or value truncation flag
//
// state  | meaning
// IDLE   | between messages; first byte starts a message, or a lookup starts
// TAG    | accumulating decimal tag digits up to '='
// VALUE  | collecting value bytes up to SOH
// HUNT   | discarding bytes after an abort until SOH
// LOOKUP | scanning the table one entry per cycle
module fix_field_store #(
   parameter  int TAG_WIDTH   = 32,
   parameter  int VALUE_BYTES = 32,
   parameter  int DEPTH       = 32,
   localparam int IDX_W       = $clog2(DEPTH + 1),
   localparam int LEN_W       = $clog2(VALUE_BYTES + 1)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [7:0]               data_i,
   input  logic                     data_valid_i,
   output logic                     data_ready_o,
   input  logic [TAG_WIDTH-1:0]     find_tag_i,
   input  logic                     lookup_req_i,
   output logic                     lookup_done_o,
   output logic                     lookup_hit_o,
   output logic [8*VALUE_BYTES-1:0] value_o,
   output logic [LEN_W-1:0]         value_len_o,
   output logic                     msg_done_o,
   output logic                     msg_ok_o,
   output logic [IDX_W-1:0]         field_count_o,
   output logic [7:0]               checksum_o,
   output logic                     overflow_o
);

   localparam int         AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [7:0] SOH = 8'h01;
   localparam logic [7:0] EQ  = 8'h3D;

   typedef enum logic [2:0] {S_IDLE, S_TAG, S_VALUE, S_HUNT, S_LOOKUP} state_t;

   state_t                   state_q, state_d;
   logic [TAG_WIDTH-1:0]     tag_q, find_q;
   logic                     tag_nz_q;
   logic [8*VALUE_BYTES-1:0] vbuf_q;
   logic [LEN_W-1:0]         vlen_q;
   logic [7:0]               vdec_q, sum_q, sum_mark_q;
   logic [IDX_W-1:0]         count_q, idx_q;
   logic                     msg_done_q, msg_ok_q, overflow_q;
   logic [7:0]               checksum_q;
   logic                     lk_done_q, lk_hit_q;
   logic [8*VALUE_BYTES-1:0] value_q;
   logic [LEN_W-1:0]         value_len_q;

   logic [TAG_WIDTH-1:0]     tag_tab [DEPTH];
   logic [8*VALUE_BYTES-1:0] val_tab [DEPTH];
   logic [LEN_W-1:0]         len_tab [DEPTH];

   logic       ready, accept, msg_start, abort, field_end, msg_end;
   logic       is_digit, tag_is_10, tab_full, lk_match, lk_last;
   logic [7:0] digit;

   assign is_digit  = (data_i >= 8'h30) && (data_i <= 8'h39);
   assign digit     = data_i - 8'h30;
   assign tag_is_10 = (tag_q == TAG_WIDTH'(10));
   assign tab_full  = (count_q == IDX_W'(DEPTH));
   assign lk_match  = (tag_tab[idx_q[AW-1:0]] == find_q);
   assign lk_last   = ((idx_q + IDX_W'(1)) == count_q);

   // output / decode
   always_comb begin
      ready = 1'b1;
      if (state_q == S_LOOKUP) begin
         ready = 1'b0;
      end else if ((state_q == S_IDLE) && lookup_req_i) begin
         ready = 1'b0;
      end
      accept    = data_valid_i && ready;
      msg_start = accept && (state_q == S_IDLE);
      abort     = 1'b0;
      if (accept) begin
         case (state_q)
            S_IDLE:  abort = !is_digit;
            // '=' is only legal once at least one digit has been seen
            S_TAG:   abort = !is_digit && !((data_i == EQ) && tag_nz_q);
            default: abort = 1'b0;
         endcase
      end
      field_end = accept && (state_q == S_VALUE) && (data_i == SOH);
      msg_end   = field_end && tag_is_10;
   end

   // next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (lookup_req_i) begin
               // an empty table completes immediately without scanning
               if (count_q != '0) state_d = S_LOOKUP;
            end else if (accept) begin
               state_d = abort ? S_HUNT : S_TAG;
            end
         end
         S_TAG: begin
            if (abort)                        state_d = S_HUNT;
            else if (accept && data_i == EQ)  state_d = S_VALUE;
         end
         S_VALUE:  if (field_end) state_d = msg_end ? S_IDLE : S_TAG;
         S_HUNT:   if (accept && data_i == SOH) state_d = S_IDLE;
         S_LOOKUP: if (lk_match || lk_last) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clk) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   // field table storage; entries at or above count_q are never read
   always_ff @(posedge clk) begin
      if (field_end && !tab_full) begin
         tag_tab[count_q[AW-1:0]] <= tag_q;
         val_tab[count_q[AW-1:0]] <= vbuf_q;
         len_tab[count_q[AW-1:0]] <= vlen_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         tag_q       <= '0;
         find_q      <= '0;
         tag_nz_q    <= 1'b0;
         vbuf_q      <= '0;
         vlen_q      <= '0;
         vdec_q      <= '0;
         sum_q       <= '0;
         sum_mark_q  <= '0;
         count_q     <= '0;
         idx_q       <= '0;
         msg_done_q  <= 1'b0;
         msg_ok_q    <= 1'b0;
         overflow_q  <= 1'b0;
         checksum_q  <= '0;
         lk_done_q   <= 1'b0;
         lk_hit_q    <= 1'b0;
         value_q     <= '0;
         value_len_q <= '0;
      end else begin
         msg_done_q <= 1'b0;
         lk_done_q  <= 1'b0;

         if (msg_start) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
            sum_q      <= data_i;
            sum_mark_q <= '0;
            tag_q      <= TAG_WIDTH'(digit);
            tag_nz_q   <= 1'b1;
         end

         if (accept && (state_q == S_TAG || state_q == S_VALUE)) begin
            sum_q <= sum_q + data_i;
         end

         if (accept && state_q == S_TAG) begin
            if (is_digit) begin
               tag_q    <= tag_q * TAG_WIDTH'(10) + TAG_WIDTH'(digit);
               tag_nz_q <= 1'b1;
            end else if (data_i == EQ && tag_nz_q) begin
               vbuf_q <= '0;
               vlen_q <= '0;
               vdec_q <= '0;
            end
         end

         if (accept && state_q == S_VALUE && data_i != SOH) begin
            if (vlen_q == LEN_W'(VALUE_BYTES)) begin
               overflow_q <= 1'b1;
            end else begin
               for (int k = 0; k < VALUE_BYTES; k++) begin
                  if (vlen_q == LEN_W'(k)) vbuf_q[8*k +: 8] <= data_i;
               end
               vlen_q <= vlen_q + LEN_W'(1);
            end
            vdec_q <= vdec_q * 8'd10 + digit;
         end

         if (field_end) begin
            if (tab_full) overflow_q <= 1'b1;
            else          count_q    <= count_q + IDX_W'(1);
            // snapshot through this SOH so a following tag-10 field is excluded
            sum_mark_q <= sum_q + data_i;
            tag_q      <= '0;
            tag_nz_q   <= 1'b0;
            if (tag_is_10) begin
               msg_done_q <= 1'b1;
               checksum_q <= sum_mark_q;
`ifdef FIX_CHECKSUM_CHECK_EN
               msg_ok_q   <= (sum_mark_q == vdec_q);
`else
               msg_ok_q   <= 1'b1;
`endif
            end
         end

         if (abort) begin
            msg_done_q <= 1'b1;
            msg_ok_q   <= 1'b0;
         end

         if (state_q == S_IDLE && lookup_req_i) begin
            find_q <= find_tag_i;
            idx_q  <= '0;
            if (count_q == '0) begin
               lk_done_q   <= 1'b1;
               lk_hit_q    <= 1'b0;
               value_q     <= '0;
               value_len_q <= '0;
            end
         end

         if (state_q == S_LOOKUP) begin
            if (lk_match) begin
               lk_done_q   <= 1'b1;
               lk_hit_q    <= 1'b1;
               value_q     <= val_tab[idx_q[AW-1:0]];
               value_len_q <= len_tab[idx_q[AW-1:0]];
            end else if (lk_last) begin
               lk_done_q   <= 1'b1;
               lk_hit_q    <= 1'b0;
               value_q     <= '0;
               value_len_q <= '0;
            end else begin
               idx_q <= idx_q + IDX_W'(1);
            end
         end
      end
   end

   assign data_ready_o  = ready;
   assign lookup_done_o = lk_done_q;
   assign lookup_hit_o  = lk_hit_q;
   assign value_o       = value_q;
   assign value_len_o   = value_len_q;
   assign msg_done_o    = msg_done_q;
   assign msg_ok_o      = msg_ok_q;
   assign field_count_o = count_q;
   assign checksum_o    = checksum_q;
   assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_fix_field_store.sv
// Testbench for fix_field_store (DEPTH=4, VALUE_BYTES=8 to reach the
// table-full and value-truncation corners with short messages).
module tb_fix_field_store;

   localparam int TW = 32;
   localparam int VB = 8;
   localparam int DP = 4;
   localparam int IW = $clog2(DP + 1);
   localparam int LW = $clog2(VB + 1);

   logic            clk;
   logic            rst;
   logic [7:0]      data_i;
   logic            data_valid_i;
   logic            data_ready_o;
   logic [TW-1:0]   find_tag_i;
   logic            lookup_req_i;
   logic            lookup_done_o;
   logic            lookup_hit_o;
   logic [8*VB-1:0] value_o;
   logic [LW-1:0]   value_len_o;
   logic            msg_done_o;
   logic            msg_ok_o;
   logic [IW-1:0]   field_count_o;
   logic [7:0]      checksum_o;
   logic            overflow_o;

   fix_field_store #(.TAG_WIDTH(TW), .VALUE_BYTES(VB), .DEPTH(DP)) dut (
      .clk          (clk),
      .rst          (rst),
      .data_i       (data_i),
      .data_valid_i (data_valid_i),
      .data_ready_o (data_ready_o),
      .find_tag_i   (find_tag_i),
      .lookup_req_i (lookup_req_i),
      .lookup_done_o(lookup_done_o),
      .lookup_hit_o (lookup_hit_o),
      .value_o      (value_o),
      .value_len_o  (value_len_o),
      .msg_done_o   (msg_done_o),
      .msg_ok_o     (msg_ok_o),
      .field_count_o(field_count_o),
      .checksum_o   (checksum_o),
      .overflow_o   (overflow_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic          ok;
      logic [IW-1:0] cnt;
      logic [7:0]    ck;
      logic          ovf;
   } msg_exp_t;

   msg_exp_t   exp_q[$];
   msg_exp_t   mexp;
   int         n_checks = 0;
   int         n_pass   = 0;
   logic [7:0] last_ck  = 8'h00;

   // scoreboard side: every msg_done_o pops one expected message result
   always @(negedge clk) begin
      if (msg_done_o === 1'b1) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL unexpected_msg_done: got pulse, required none");
         end else begin
            n_pass++;
            mexp = exp_q.pop_front();
            n_checks++;
            if (msg_ok_o !== mexp.ok) $display("FAIL msg_ok: got %0b required %0b", msg_ok_o, mexp.ok);
            else n_pass++;
            n_checks++;
            if (field_count_o !== mexp.cnt) $display("FAIL msg_field_count: got %0d required %0d", field_count_o, mexp.cnt);
            else n_pass++;
            n_checks++;
            if (checksum_o !== mexp.ck) $display("FAIL msg_checksum: got %0d required %0d", checksum_o, mexp.ck);
            else n_pass++;
            n_checks++;
            if (overflow_o !== mexp.ovf) $display("FAIL msg_overflow: got %0b required %0b", overflow_o, mexp.ovf);
            else n_pass++;
         end
      end
   end

   function automatic logic [7:0] map_byte(input byte c);
      return (c == "|") ? 8'h01 : 8'(c);
   endfunction

   function automatic logic [8*VB-1:0] pack_val(input string s);
      logic [8*VB-1:0] v = '0;
      for (int k = 0; k < s.len() && k < VB; k++) v[8*k +: 8] = 8'(s[k]);
      return v;
   endfunction

   task automatic send_byte(input logic [7:0] b);
      data_i       = b;
      data_valid_i = 1'b1;
      @(posedge clk);
      #1;
      data_valid_i = 1'b0;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(map_byte(s[i]));
   endtask

   // Builds "<body>10=ccc|" where ccc = checksum(body)+delta, and queues the
   // expected outcome from an independent parse of the body.
   task automatic send_msg(input string body, input int delta);
      logic [7:0] s = 8'h00;
      int nf = 0;
      int vlen = 0;
      bit in_val = 0;
      bit ovf = 0;
      msg_exp_t e;
      string tail;
      for (int i = 0; i < body.len(); i++) begin
         s = s + map_byte(body[i]);
         if (body[i] == "=") begin
            in_val = 1; vlen = 0;
         end else if (body[i] == "|") begin
            nf++; in_val = 0;
         end else if (in_val) begin
            vlen++;
            if (vlen > VB) ovf = 1;
         end
      end
      nf = nf + 1;
      if (nf > DP) ovf = 1;
      tail = $sformatf("10=%03d|", (int'(s) + delta) & 255);
`ifdef FIX_CHECKSUM_CHECK_EN
      e.ok = (delta == 0);
`else
      e.ok = 1'b1;
`endif
      e.cnt = IW'((nf > DP) ? DP : nf);
      e.ck  = s;
      e.ovf = ovf;
      exp_q.push_back(e);
      last_ck = s;
      send_str({body, tail});
   endtask

   task automatic wait_msgs(input string nm);
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
      n_checks++;
      if (exp_q.size() != 0) $display("FAIL %s_timeout: %0d messages still pending, required 0", nm, exp_q.size());
      else n_pass++;
      @(posedge clk);
      #1;
   endtask

   typedef struct packed {
      logic          hit;
      logic [8*VB-1:0] val;
      logic [LW-1:0] len;
      int            lat;
   } lk_exp_t;
   lk_exp_t lk_q[$];

   task automatic do_lookup(input logic [TW-1:0] tag, input logic hit, input string val,
                            input int lat, input string nm);
      lk_exp_t e;
      int n = 0;
      e.hit = hit;
      e.val = hit ? pack_val(val) : '0;
      e.len = hit ? LW'((val.len() > VB) ? VB : val.len()) : '0;
      e.lat = lat;
      lk_q.push_back(e);
      @(posedge clk);
      #1;
      lookup_req_i = 1'b1;
      find_tag_i   = tag;
      @(posedge clk);
      #1;
      lookup_req_i = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (lookup_done_o === 1'b1) begin
            n = i;
            break;
         end
      end
      e = lk_q.pop_front();
      n_checks++;
      if (n != e.lat) $display("FAIL %s_latency: got %0d cycles required %0d", nm, n, e.lat);
      else n_pass++;
      n_checks++;
      if (lookup_hit_o !== e.hit) $display("FAIL %s_hit: got %0b required %0b", nm, lookup_hit_o, e.hit);
      else n_pass++;
      n_checks++;
      if (value_o !== e.val) $display("FAIL %s_value: got %h required %h", nm, value_o, e.val);
      else n_pass++;
      n_checks++;
      if (value_len_o !== e.len) $display("FAIL %s_len: got %0d required %0d", nm, value_len_o, e.len);
      else n_pass++;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (data_ready_o !== 1'b1) $display("FAIL reset_ready: got %b required 1", data_ready_o); else n_pass++;
      n_checks++;
      if ({msg_done_o, msg_ok_o, lookup_done_o, lookup_hit_o, overflow_o} !== 5'b0)
         $display("FAIL reset_flags: got %b required 00000", {msg_done_o, msg_ok_o, lookup_done_o, lookup_hit_o, overflow_o});
      else n_pass++;
      n_checks++;
      if ({field_count_o, checksum_o, value_len_o} !== '0)
         $display("FAIL reset_counts: got %h required 0", {field_count_o, checksum_o, value_len_o});
      else n_pass++;
      n_checks++;
      if (value_o !== '0) $display("FAIL reset_value: got %h required 0", value_o); else n_pass++;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic;
      send_msg("8=FIX.4.2|35=A|", 0);
      wait_msgs("basic");
      do_lookup(35, 1'b1, "A", 3, "lookup_35");
      do_lookup(99, 1'b0, "", 4, "lookup_99");
      do_lookup(8, 1'b1, "FIX.4.2", 2, "lookup_8");
   endtask

   task automatic test_bad_checksum;
      send_msg("8=FIX.4.2|35=A|", 1);
      wait_msgs("bad_checksum");
   endtask

   task automatic test_abort;
      msg_exp_t e;
      e.ok = 1'b0; e.cnt = '0; e.ck = last_ck; e.ovf = 1'b0;
      exp_q.push_back(e);
      send_str("3A=1|");
      send_msg("8=FIX.4.2|35=D|", 0);
      wait_msgs("abort");
   endtask

   task automatic test_depth;
      send_msg("1=a|2=b|3=c|4=d|5=e|", 0);
      wait_msgs("depth");
      do_lookup(5, 1'b0, "", 5, "lookup_5th");
      do_lookup(4, 1'b1, "d", 5, "lookup_4th");
      do_lookup(1, 1'b1, "a", 2, "lookup_1st");
   endtask

   task automatic test_truncate;
      send_msg("55=ABCDEFGHIJ|", 0);
      wait_msgs("truncate");
      do_lookup(55, 1'b1, "ABCDEFGHIJ", 2, "lookup_trunc");
   endtask

   task automatic test_back_to_back;
      send_msg("9=12|35=8|", 0);
      send_msg("7=x|", 0);
      wait_msgs("back_to_back");
   endtask

   // lookup and a data byte in the same IDLE cycle: the lookup wins
   task automatic test_collision;
      int n = 0;
      @(posedge clk);
      #1;
      lookup_req_i = 1'b1;
      find_tag_i   = 999;
      data_i       = "9";
      data_valid_i = 1'b1;
      #1;
      n_checks++;
      if (data_ready_o !== 1'b0) $display("FAIL collision_ready: got %b required 0", data_ready_o); else n_pass++;
      @(posedge clk);
      #1;
      lookup_req_i = 1'b0;
      data_valid_i = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (lookup_done_o === 1'b1) begin
            n = i;
            break;
         end
      end
      n_checks++;
      if (n != 3) $display("FAIL collision_latency: got %0d cycles required 3", n); else n_pass++;
      n_checks++;
      if (field_count_o !== IW'(2)) $display("FAIL collision_count: got %0d required 2", field_count_o); else n_pass++;
      @(posedge clk);
      #1;
   endtask

   task automatic test_mid_reset;
      send_str("8=FIX|35=AB");
      @(negedge clk);
      n_checks++;
      if (field_count_o !== IW'(1)) $display("FAIL midreset_precount: got %0d required 1", field_count_o); else n_pass++;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if (field_count_o !== '0) $display("FAIL midreset_count: got %0d required 0", field_count_o); else n_pass++;
      n_checks++;
      if (data_ready_o !== 1'b1) $display("FAIL midreset_ready: got %b required 1", data_ready_o); else n_pass++;
      n_checks++;
      if (msg_done_o !== 1'b0) $display("FAIL midreset_done: got %b required 0", msg_done_o); else n_pass++;
      last_ck = 8'h00;
      repeat (5) @(posedge clk);
      #1;
      do_lookup(8, 1'b0, "", 1, "lookup_empty");
      send_msg("49=ABC|56=XY|", 0);
      wait_msgs("after_reset");
   endtask

   initial begin
      rst          = 1'b0;
      data_i       = 8'h00;
      data_valid_i = 1'b0;
      find_tag_i   = '0;
      lookup_req_i = 1'b0;
      test_reset;
      test_basic;
      test_bad_checksum;
      test_abort;
      test_depth;
      test_truncate;
      test_back_to_back;
      test_collision;
      test_mid_reset;
      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fix_field_store.md
FIX_FIELD_STORE -- requirements
Module: fix_field_store

Interface
REQ-001 SHALL have parameter TAG_WIDTH, default 32: width of the binary tag number.
REQ-002 SHALL have parameter VALUE_BYTES, default 32: maximum stored value length in bytes.
REQ-003 SHALL have parameter DEPTH, default 32: field table entries; IDX_W = $clog2(DEPTH+1), LEN_W = $clog2(VALUE_BYTES+1).
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-low reset.
REQ-006 data_i  input  8  ASCII FIX byte stream.
REQ-007 data_valid_i  input  1  data_i valid; byte accepted when data_valid_i && data_ready_o.
REQ-008 data_ready_o  output  1  block can accept a byte.
REQ-009 find_tag_i  input  TAG_WIDTH  tag to look up; sampled with lookup_req_i.
REQ-010 lookup_req_i  input  1  one-cycle lookup request.
REQ-011 lookup_done_o  output  1  one-cycle pulse ending a lookup.
REQ-012 lookup_hit_o  output  1  tag found; valid with lookup_done_o.
REQ-013 value_o  output  8*VALUE_BYTES  matched value, byte k at bits [8k+7:8k], unused bytes zero.
REQ-014 value_len_o  output  LEN_W  matched value byte count.
REQ-015 msg_done_o  output  1  one-cycle pulse at message end or abort.
REQ-016 msg_ok_o  output  1  message status; valid with msg_done_o, held until next msg_done_o.
REQ-017 field_count_o  output  IDX_W  fields stored for current/last message.
REQ-018 checksum_o  output  8  computed checksum of last completed message.
REQ-019 overflow_o  output  1  sticky: table or value truncation in current/last message.

Function
REQ-020 FSM states SHALL be IDLE, TAG, VALUE, HUNT, LOOKUP.
- IDLE: first accepted byte starts message; clears table, count, overflow, sum; enters TAG, processing the byte as a tag byte.
- TAG: digits give tag = tag*10 + (byte-0x30), truncated modulo 2^TAG_WIDTH; '=' (0x3D) -> VALUE; any other byte -> abort.
- VALUE: bytes packed from byte 0 upward; bytes beyond VALUE_BYTES dropped and overflow_o set; SOH (0x01) stores the field and enters TAG, except after tag 10, which ends the message and enters IDLE.
- HUNT: discards bytes until SOH, then IDLE.
REQ-021 A field SHALL be written at index field_count_o, then the count increments; with the count at DEPTH, the field is discarded, overflow_o set, and parsing continues.
REQ-022 The running sum SHALL be the modulo-256 sum of all accepted bytes from message start through the SOH preceding the "10=" tag bytes; the tag-10 field is excluded.
REQ-023 The tag-10 value SHALL be decoded as decimal modulo 256; checksum_o SHALL update at message end.
REQ-024 msg_done_o SHALL pulse in the cycle after the terminating SOH is accepted.
REQ-025 Abort (bad tag byte, empty tag before '=', or SOH in TAG state) SHALL pulse msg_done_o with msg_ok_o=0 the cycle after the offending byte and enter HUNT.
REQ-026 data_ready_o SHALL be 1 in IDLE/TAG/VALUE/HUNT and 0 in LOOKUP.
REQ-027 lookup_req_i SHALL be accepted only in IDLE; if it coincides with data_valid_i in IDLE, the lookup wins and data_ready_o is 0 in that cycle; requests in other states are ignored.
REQ-028 LOOKUP SHALL scan one entry per cycle from index 0; the first match ends the scan.
REQ-029 The lookup SHALL complete with lookup_done_o exactly k+2 cycles after request on a hit at index k, and field_count_o+1 cycles after request on a miss.
REQ-030 On a miss, value_o and value_len_o SHALL be 0 and lookup_hit_o 0; on completion the FSM returns to IDLE.

Reset
REQ-031 While rst=0: state IDLE, table/count/sum cleared; all outputs 0 except data_ready_o=1 from the first cycle after reset release; reset mid-message or mid-lookup SHALL discard all state without a pulse.

Configuration
REQ-032 With FIX_CHECKSUM_CHECK_EN defined: msg_ok_o=1 at end only if the computed sum equals the decoded tag-10 value.
REQ-033 Without FIX_CHECKSUM_CHECK_EN: the comparison is omitted and msg_ok_o=1 at every non-aborted end; checksum_o is still computed.

Verification
REQ-034 "8=FIX.4.2|35=A|10=xxx|" with the correct checksum (| = SOH) -> msg_done_o pulses, msg_ok_o=1, field_count_o=3, checksum_o=xxx.
REQ-035 Same message with the tag-10 value off by one -> msg_ok_o=0 with macro, 1 without; checksum_o unchanged.
REQ-036 After REQ-034, lookup 35 -> lookup_done_o exactly 3 cycles after request, hit=1, value_o[7:0]=0x41, value_len_o=1; lookup 99 -> done 4 cycles after request, hit=0.
REQ-037 DEPTH=4, a message with 6 fields -> field_count_o=4, overflow_o=1; lookup of the 5th tag misses; msg_ok_o still correct.
REQ-038 "3A=1|" -> abort pulse, msg_ok_o=0; bytes are discarded to SOH; the next valid message parses with msg_ok_o=1.
REQ-039 rst=0 asserted mid-VALUE -> next cycle field_count_o=0, no msg_done_o, data_ready_o=1.
